// File: rtl/compl_mul_round_pkg.sv
// Shared widths and component types for the complex multiply-round datapath.
package compl_mul_round_pkg;

    localparam int IN_W_DEF   = 18;
    localparam int FRAC_W_DEF = 16;
    localparam int OUT_W_DEF  = 19;
    // Two products summed: one extra bit over the full product width avoids overflow.
    localparam int SUM_W_DEF  = 2 * IN_W_DEF + 1;

    typedef logic signed [IN_W_DEF-1:0]  in_t;
    typedef logic signed [SUM_W_DEF-1:0] sum_t;
    typedef logic signed [OUT_W_DEF-1:0] out_t;

endpackage

// File: rtl/compl_mul_round_round_sat.sv
// Round-half-up by FRAC_W bits, then saturate (COMPL_MUL_ROUND_SAT_EN) or wrap to OUT_W.
module round_sat
    import compl_mul_round_pkg::*;
#(
    parameter int SUM_W  = SUM_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [SUM_W-1:0] sum,
    output logic [OUT_W-1:0] result
);

    localparam int EXT_W = SUM_W + 1;
    localparam int RND_W = EXT_W - FRAC_W;
    localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (FRAC_W - 1);

    logic [EXT_W-1:0] biased;
    logic [RND_W-1:0] rounded;

    // Sign-extend by one bit so the rounding offset can never overflow; taking the
    // upper bits is then an exact arithmetic shift right.
    assign biased  = {sum[SUM_W-1], sum} + HALF;
    assign rounded = biased[EXT_W-1:FRAC_W];

    generate
        if (RND_W > OUT_W) begin : g_narrow
`ifdef COMPL_MUL_ROUND_SAT_EN
            logic [RND_W-OUT_W:0] top_bits;
            logic                 fits;

            assign top_bits = rounded[RND_W-1:OUT_W-1];
            assign fits     = (&top_bits) | (~|top_bits);

            always_comb begin
                if (fits) begin
                    result = rounded[OUT_W-1:0];
                end else if (rounded[RND_W-1]) begin
                    result = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    result = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
`else
            assign result = rounded[OUT_W-1:0];
`endif
        end else begin : g_wide
            assign result = {{(OUT_W-RND_W){rounded[RND_W-1]}}, rounded};
        end
    endgenerate

endmodule

// File: rtl/compl_mul_round.sv
// Registered complex multiply (a * b, b in Q1.FRAC_W) with rounding; saturation is
// selected by COMPL_MUL_ROUND_SAT_EN, otherwise results wrap to OUT_W bits.
module compl_mul_round
    import compl_mul_round_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic signed [IN_W-1:0]  data_a_i_i,
    input  logic signed [IN_W-1:0]  data_a_q_i,
    input  logic signed [IN_W-1:0]  data_b_i_i,
    input  logic signed [IN_W-1:0]  data_b_q_i,
    output logic signed [OUT_W-1:0] data_i_o,
    output logic signed [OUT_W-1:0] data_q_o
);

    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] prod_ii, prod_qq, prod_iq, prod_qi;
    logic signed [SUM_W-1:0]  sum_re, sum_im;
    logic        [OUT_W-1:0]  rnd_re, rnd_im;

    assign prod_ii = data_a_i_i * data_b_i_i;
    assign prod_qq = data_a_q_i * data_b_q_i;
    assign prod_iq = data_a_i_i * data_b_q_i;
    assign prod_qi = data_a_q_i * data_b_i_i;

    assign sum_re = SUM_W'(prod_ii) - SUM_W'(prod_qq);
    assign sum_im = SUM_W'(prod_iq) + SUM_W'(prod_qi);

    round_sat #(
        .SUM_W  (SUM_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_round_re (
        .sum    (sum_re),
        .result (rnd_re)
    );

    round_sat #(
        .SUM_W  (SUM_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_round_im (
        .sum    (sum_im),
        .result (rnd_im)
    );

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            data_i_o <= '0;
            data_q_o <= '0;
        end else begin
            data_i_o <= rnd_re;
            data_q_o <= rnd_im;
        end
    end

endmodule

// File: tb/tb_compl_mul_round.sv
// Directed vector bench for compl_mul_round; expectations follow COMPL_MUL_ROUND_SAT_EN.
module tb_compl_mul_round;
    import compl_mul_round_pkg::*;

    typedef struct {
        in_t  ai, aq, bi, bq;
        out_t ei, eq;
    } vec_t;

    localparam int NVEC = 12;

    logic clk, srst;
    in_t  a_i, a_q, b_i, b_q;
    out_t d_i, d_q;
    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    compl_mul_round dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .data_a_i_i (a_i),
        .data_a_q_i (a_q),
        .data_b_i_i (b_i),
        .data_b_q_i (b_q),
        .data_i_o   (d_i),
        .data_q_o   (d_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(int ai, int aq, int bi, int bq, int ei, int eq);
        vec_t v;
        v.ai = in_t'(ai);
        v.aq = in_t'(aq);
        v.bi = in_t'(bi);
        v.bq = in_t'(bq);
        v.ei = out_t'(ei);
        v.eq = out_t'(eq);
        return v;
    endfunction

    task automatic chk(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_i = v.ai;
        a_q = v.aq;
        b_i = v.bi;
        b_q = v.bq;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 65536, 0, 1, 0);
        vecs[1]  = mk(1, 1, 65536, 65536, 0, 2);
        vecs[2]  = mk(24, 0, 'h15000, 0, 32, 0);
        vecs[3]  = mk(24, 0, -45056, 0, -16, 0);            // b = 0x35000
        vecs[4]  = mk(-131048, 0, 'h15000, 0, -172000, 0);  // a = 0x20018
        vecs[5]  = mk(-1, -87382, -45056, 98304, 131074, 60074);
        vecs[6]  = mk(131071, 0, 131071, 0, 262140, 0);
`ifdef COMPL_MUL_ROUND_SAT_EN
        vecs[7]  = mk(-131072, 0, -131072, 0, 262143, 0);
        vecs[8]  = mk(-131072, 131071, 131071, 131071, -262144, -2);
        vecs[9]  = mk(131071, 131071, 131071, 131071, 0, 262143);
`else
        vecs[7]  = mk(-131072, 0, -131072, 0, -262144, 0);
        vecs[8]  = mk(-131072, 131071, 131071, 131071, 6, -2);
        vecs[9]  = mk(131071, 131071, 131071, 131071, 0, -8);
`endif
        vecs[10] = mk(3, 0, -32768, 0, -1, 0);              // -1.5 rounds to -1
        vecs[11] = mk(0, 5, 0, -13107, 1, 0);

        // Reset is immediate and swallows the operands present at the first edge.
        srst = 1'b1;
        drive(vecs[0]);
        #1;
        chk("reset_async_i", d_i, out_t'(0));
        chk("reset_async_q", d_q, out_t'(0));
        @(posedge clk);
        #1;
        chk("reset_edge_i", d_i, out_t'(0));
        #2 srst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_out_i", d_i, vecs[0].ei);
        chk("first_out_q", d_q, vecs[0].eq);

        // Back-to-back stream: one new operand set per clock.
        for (int i = 1; i < NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_i", i), d_i, vecs[i].ei);
            chk($sformatf("vec%0d_q", i), d_q, vecs[i].eq);
        end

        // Outputs hold between edges even when inputs change.
        drive(vecs[5]);
        #2;
        chk("hold_i", d_i, vecs[NVEC-1].ei);
        chk("hold_q", d_q, vecs[NVEC-1].eq);
        @(posedge clk);
        #1;
        chk("pre_rst_i", d_i, vecs[5].ei);

        // Mid-stream reset between edges, held across an edge, released between edges.
        drive(vecs[6]);
        #2 srst = 1'b1;
        #1;
        chk("mid_rst_i", d_i, out_t'(0));
        chk("mid_rst_q", d_q, out_t'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_edge_i", d_i, out_t'(0));
        #2 srst = 1'b0;
        #1;
        chk("post_rel_i", d_i, out_t'(0));
        @(posedge clk);
        #1;
        chk("resume_i", d_i, vecs[6].ei);
        chk("resume_q", d_q, vecs[6].eq);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
